io_bridge: RTL and testbench
============================

# io_bridge

Memory-mapped I/O bridge directly downstream of the CPU core's byte-wide memory bus. Steers each bus access either to the 128 KB RAM or to the I/O window (`mem_a[17:16]==2'b11`). Buffers UART transmit and receive bytes in FIFOs, drives `io_buffer_full` back to the core, and provides the cycle counter and the program-stop flag.

## Interface
- `TX_DEPTH_LOG2`, 4: log2 of TX FIFO entries (16).
- `RX_DEPTH_LOG2`, 4: log2 of RX FIFO entries (16).
- `FULL_MARGIN`, 2: free TX slots at or below which `io_buffer_full` asserts.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  core ready; bus accesses are ignored while low.
- `cpu_a`  in  32  core address bus; only [17:0] is decoded.
- `cpu_wr`  in  1  1 = write.
- `cpu_dout`  in  8  write data from the core.
- `cpu_din`  out  8  read data to the core.
- `ram_a`  out  17  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  8  RAM write data.
- `ram_rdata`  in  8  RAM read data, valid 1 cycle after `ram_a`.
- `tx_data`  out  8  UART TX byte.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  UART accepts `tx_data` this cycle.
- `rx_data`  in  8  UART RX byte.
- `rx_valid`  in  1  RX byte offered.
- `io_buffer_full`  out  1  TX FIFO near full; goes to the core.
- `program_done`  out  1  sticky; set by the stop write.

## Operation
- Decode: `is_io = cpu_a[17:16]==2'b11`. RAM path is combinational.
  - `ram_a = cpu_a[16:0]`, `ram_wdata = cpu_dout`.
  - `ram_we = rdy_in & cpu_wr & ~is_io`.
- I/O write, `rdy_in=1`, `cpu_a[17:0]==0x30000`, data ≠ 0: push `cpu_dout` to TX FIFO. Data 0x00 is ignored.
- I/O write to `0x30004`: push 0x00 to TX FIFO and set `program_done`.
  - `program_done` stays set until reset.
  - Further writes to `0x30004` still push 0x00.
- I/O read of `0x30000`: pop the RX FIFO head and return it. Empty FIFO returns 0x00 and does not pop.
- I/O read of `0x30004`: latch a 32-bit snapshot of `cycle_cnt` and return its byte 0.
- I/O read of `0x30005`–`0x30007`: return snapshot byte `cpu_a[1:0]` without re-latching.
- Any other I/O address: reads return 0x00, writes are dropped.
- `cycle_cnt`: 32-bit, cleared by reset, +1 every clock regardless of `rdy_in`, wraps 0xFFFFFFFF→0.
- TX FIFO: circular, pointers wrap modulo depth, count width `TX_DEPTH_LOG2+1`.
  - Pop when `tx_valid & tx_ready`.
  - Push while full is dropped.
  - Simultaneous push and pop leaves count unchanged; this is legal even when full, because the pop frees the slot first.
- `io_buffer_full = (TX_DEPTH - count) <= FULL_MARGIN`. This margin covers stores already issued by the core.
- RX FIFO: same structure. Push on `rx_valid` when not full; a byte offered while full is lost. Simultaneous push and pop are legal.

## Timing
- `cpu_din` is valid 1 cycle after the address: `cpu_din = sel_io_q ? io_rdata_q : ram_rdata`.
  - `sel_io_q` and `io_rdata_q` are registered only when `rdy_in=1`; they hold while `rdy_in=0`.
- FIFO pops caused by reads and snapshot latching happen at the same edge that registers `io_rdata_q`.
- An RX byte pushed at edge N is readable by a read presented in cycle N+1 or later.
- A TX byte pushed at edge N appears on `tx_data` with `tx_valid=1` in cycle N+1.
- `io_buffer_full` is registered and reflects the count after edge N.
- Reset (async, any time, including mid-transfer) forces:
  - both FIFOs empty, `tx_valid=0`, `tx_data=0x00`;
  - `io_buffer_full=0`, `program_done=0`, `cycle_cnt=0`, snapshot 0;
  - `sel_io_q=0`, `io_rdata_q=0x00`, so `cpu_din` follows `ram_rdata`.
- `ram_we` is combinational and is low during reset only if `cpu_wr` is low. The core drives `cpu_wr=0` during reset.

## Configuration
- `IO_BRIDGE_RX_EN` defined: RX FIFO and `0x30000` read path present as described.
- `IO_BRIDGE_RX_EN` undefined: no RX FIFO; `rx_valid` is ignored and `0x30000` reads return 0x00. All other behaviour is identical.

## Test plan
- Write 0x41 to `0x30000` with `tx_ready=1` → `tx_data=0x41`, `tx_valid=1` next cycle, popped the cycle after. `ram_we` stays 0.
- 14 writes with `tx_ready=0` (depth 16, margin 2) → `io_buffer_full=1` after the 14th. 17th and later writes dropped. Drain all 16 → order preserved, `tx_valid=0`.
- Write 0x00 to `0x30000` → no push. Write any byte to `0x30004` → one 0x00 pushed, `program_done=1`.
- Read `0x30004`..`0x30007` at `cycle_cnt=0x12345678` → bytes 0x78, 0x56, 0x34, 0x12 across four reads, despite counter advance.
- RX path (`IO_BRIDGE_RX_EN`): push 0x55, 0xAA; three reads of `0x30000` → 0x55, 0xAA, 0x00.
- RAM write/read at `0x01234` with value 0xC3, a `rdy_in=0` stall between, and async reset mid-FIFO-fill → `cpu_din` returns 0xC3 one cycle after the read address. After reset, FIFOs are empty and `program_done=0`.

Source files
------------

// File: rtl/io_bridge.sv
// ---------------------------------------------------------------------------
// io_bridge
//   Memory-mapped I/O bridge between the CPU core's byte-wide bus and the
//   128 KB RAM / UART. Accesses with cpu_a[17:16]==2'b11 go to the I/O window.
//   The rest go to RAM through a purely combinational path.
//
//   I/O map (cpu_a[17:0]):
//     0x30000  write: push a non-zero byte to the TX FIFO (0x00 is ignored)
//              read : pop the RX FIFO head (0x00 when empty)
//     0x30004  write: push 0x00 to the TX FIFO and set program_done
//              read : latch a cycle_cnt snapshot and return its byte 0
//     0x30005-0x30007  read: snapshot bytes 1..3 (no re-latch)
//
//   Ports
//     clk_in, rst_in          clock, async active-low reset
//     rdy_in                  core ready; bus accesses are ignored while low
//     cpu_a/cpu_wr/cpu_dout   core address / write strobe / write data
//     cpu_din                 read data, valid one cycle after the address
//     ram_a/ram_we/ram_wdata  RAM address / write enable / write data
//     ram_rdata               RAM read data, one cycle after ram_a
//     tx_data/tx_valid/tx_ready   UART TX byte stream (TX FIFO head)
//     rx_data/rx_valid            UART RX byte offer
//     io_buffer_full          TX FIFO has FULL_MARGIN or fewer free slots
//     program_done            sticky stop flag
//
//   Build option: define IO_BRIDGE_RX_EN to include the RX FIFO. When the
//   macro is undefined, rx_valid/rx_data are ignored and 0x30000 reads 0x00.
// ---------------------------------------------------------------------------
module io_bridge #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        io_buffer_full,
  output logic        program_done
);

  localparam int              TXW        = TX_DEPTH_LOG2;
  localparam int              TX_ENTRIES = 1 << TXW;
  localparam logic [TXW:0]    TX_DEPTH   = (TXW+1)'(TX_ENTRIES);
  localparam logic [TXW:0]    TX_MARGIN  = (TXW+1)'(FULL_MARGIN);

  // ---------------- decode and RAM path ----------------
  logic [17:0] addr;
  logic        is_io, io_wr, io_rd, stop_wr, tx_push;
  logic [7:0]  tx_wdata;
  logic        unused_addr_hi;

  assign addr           = cpu_a[17:0];
  assign unused_addr_hi = ^cpu_a[31:18];
  assign is_io          = (addr[17:16] == 2'b11);

  assign ram_a     = cpu_a[16:0];
  assign ram_wdata = cpu_dout;
  assign ram_we    = rdy_in & cpu_wr & ~is_io;

  assign io_wr    = rdy_in & cpu_wr & is_io;
  assign io_rd    = rdy_in & ~cpu_wr & is_io;
  assign stop_wr  = io_wr & (addr == 18'h30004);
  assign tx_push  = stop_wr | (io_wr & (addr == 18'h30000) & (cpu_dout != 8'h00));
  assign tx_wdata = stop_wr ? 8'h00 : cpu_dout;

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem [TX_ENTRIES];
  logic [TXW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TXW:0]   tx_count, tx_count_next;
  logic           tx_pop, tx_push_ok;

  assign tx_valid   = (tx_count != '0);
  assign tx_data    = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
  assign tx_pop     = tx_valid & tx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign tx_push_ok = tx_push & ((tx_count != TX_DEPTH) | tx_pop);

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    tx_count_next = tx_count;
    if (tx_push_ok && !tx_pop)      tx_count_next = tx_count + (TXW+1)'(1);
    else if (tx_pop && !tx_push_ok) tx_count_next = tx_count - (TXW+1)'(1);
  end

  // NOTE: FIFO storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (tx_push_ok) tx_mem[tx_wr_ptr] <= tx_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      tx_count       <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + TXW'(1);
      if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + TXW'(1);
      tx_count       <= tx_count_next;
      io_buffer_full <= (TX_DEPTH - tx_count_next) <= TX_MARGIN;
    end
  end

  // ---------------- RX FIFO (optional) ----------------
`ifdef IO_BRIDGE_RX_EN
  localparam int              RXW        = RX_DEPTH_LOG2;
  localparam int              RX_ENTRIES = 1 << RXW;
  localparam logic [RXW:0]    RX_DEPTH   = (RXW+1)'(RX_ENTRIES);

  logic [7:0]     rx_mem [RX_ENTRIES];
  logic [RXW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RXW:0]   rx_count;
  logic           rx_nonempty, rx_pop, rx_push_ok;
  logic [7:0]     rx_head;

  assign rx_nonempty = (rx_count != '0);
  assign rx_head     = rx_mem[rx_rd_ptr];
  assign rx_pop      = io_rd & (addr == 18'h30000) & rx_nonempty;
  assign rx_push_ok  = rx_valid & ((rx_count != RX_DEPTH) | rx_pop);

  always_ff @(posedge clk_in) begin
    if (rx_push_ok) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + RXW'(1);
      if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + RXW'(1);
      case ({rx_push_ok, rx_pop})
        2'b10:   rx_count <= rx_count + (RXW+1)'(1);
        2'b01:   rx_count <= rx_count - (RXW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end
`else
  logic unused_rx;
  assign unused_rx = rx_valid ^ (^rx_data);
`endif

  // ---------------- I/O read path, cycle counter, stop flag ----------------
  logic [31:0] cycle_cnt, snap;
  logic        snap_load, sel_io_q;
  logic [7:0]  io_rdata_d, io_rdata_q;

  always_comb begin
    io_rdata_d = 8'h00;
    snap_load  = 1'b0;
    if (io_rd) begin
      if (addr == 18'h30000) begin
`ifdef IO_BRIDGE_RX_EN
        if (rx_nonempty) io_rdata_d = rx_head;
`endif
      end else if (addr == 18'h30004) begin
        // Byte 0 comes straight from the counter value being latched this edge.
        io_rdata_d = cycle_cnt[7:0];
        snap_load  = 1'b1;
      end else if (addr[17:2] == 16'hC001) begin
        io_rdata_d = snap[{addr[1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt    <= '0;
      snap         <= '0;
      program_done <= 1'b0;
      sel_io_q     <= 1'b0;
      io_rdata_q   <= 8'h00;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (snap_load) snap         <= cycle_cnt;
      if (stop_wr)   program_done <= 1'b1;
      // Read-select and data hold through rdy_in stalls.
      if (rdy_in) begin
        sel_io_q   <= is_io;
        io_rdata_q <= io_rdata_d;
      end
    end
  end

  assign cpu_din = sel_io_q ? io_rdata_q : ram_rdata;

endmodule

// File: tb/tb_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_bridge
//   Randomised and directed stimulus for io_bridge. A behavioural model built
//   from queues and an associative RAM array predicts every read byte and TX
//   byte; expected values go into scoreboard queues and a monitor on the
//   falling edge pops and compares them as the DUT presents its outputs.
// ---------------------------------------------------------------------------
module tb_io_bridge;

`ifdef IO_BRIDGE_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif
  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;
  localparam int MARGIN   = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] cpu_a = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        io_buffer_full;
  logic        program_done;

  io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .ram_a(ram_a), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .io_buffer_full(io_buffer_full), .program_done(program_done)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM device attached to the DUT's RAM port ----------------
  logic [7:0] env_ram [int];
  always @(posedge clk_in) begin
    ram_rdata <= env_ram.exists(int'(ram_a)) ? env_ram[int'(ram_a)] : 8'h00;
    if (ram_we) env_ram[int'(ram_a)] = ram_wdata;
  end

  // ---------------- behavioural reference model ----------------
  logic [7:0]  m_tx[$];     // model TX FIFO contents
  logic [7:0]  tx_sb[$];    // scoreboard: bytes expected on tx_data, in order
  logic [7:0]  m_rx[$];
  logic [7:0]  rd_exp[$];   // scoreboard: expected cpu_din per read
  logic [7:0]  m_ram [int];
  logic [31:0] m_cyc, m_snap;
  bit          m_done, rd_flag;
  logic [17:0] m_a;
  bit          m_io;
  logic [7:0]  m_r;

  task automatic model_tx_push(input logic [7:0] d);
    if (m_tx.size() < TX_DEPTH) begin
      m_tx.push_back(d);
      tx_sb.push_back(d);
    end
  endtask

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_tx.delete(); tx_sb.delete(); m_rx.delete(); rd_exp.delete();
      m_cyc = 0; m_snap = 0; m_done = 0; rd_flag = 0;
    end else begin
      m_a = cpu_a[17:0];
      m_io = (m_a[17:16] == 2'b11);
      rd_flag = 0;
      if (rdy_in && !cpu_wr) begin
        m_r = 8'h00;
        if (!m_io)
          m_r = m_ram.exists(int'(m_a[16:0])) ? m_ram[int'(m_a[16:0])] : 8'h00;
        else if (m_a == 18'h30000) begin
          if (RX_EN && m_rx.size() > 0) m_r = m_rx.pop_front();
        end else if (m_a == 18'h30004) begin
          m_snap = m_cyc;
          m_r = m_cyc[7:0];
        end else if (m_a >= 18'h30005 && m_a <= 18'h30007)
          m_r = m_snap[8*m_a[1:0] +: 8];
        rd_exp.push_back(m_r);
        rd_flag = 1;
      end
      if (tx_ready && m_tx.size() > 0) void'(m_tx.pop_front());
      if (rdy_in && cpu_wr) begin
        if (!m_io) m_ram[int'(m_a[16:0])] = cpu_dout;
        else if (m_a == 18'h30000 && cpu_dout != 8'h00) model_tx_push(cpu_dout);
        else if (m_a == 18'h30004) begin
          model_tx_push(8'h00);
          m_done = 1;
        end
      end
      if (RX_EN && rx_valid && m_rx.size() < RX_DEPTH) m_rx.push_back(rx_data);
      m_cyc++;
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] mon_exp;
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (rd_flag) begin
        mon_exp = rd_exp.pop_front();
        check("cpu_din", {24'h0, cpu_din}, {24'h0, mon_exp});
      end
      check("tx_valid", {31'h0, tx_valid}, {31'h0, m_tx.size() > 0});
      if (tx_valid && tx_ready) begin
        if (tx_sb.size() > 0) begin
          mon_exp = tx_sb.pop_front();
          check("tx_data", {24'h0, tx_data}, {24'h0, mon_exp});
        end else
          check("tx_unexpected_valid", {31'h0, tx_valid}, 32'h0);
      end
      check("io_buffer_full", {31'h0, io_buffer_full},
            {31'h0, (TX_DEPTH - m_tx.size()) <= MARGIN});
      check("program_done", {31'h0, program_done}, {31'h0, m_done});
      check("ram_we", {31'h0, ram_we},
            {31'h0, rdy_in && cpu_wr && (cpu_a[17:16] != 2'b11)});
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] hi;

  task automatic bus(input bit rdy, input bit wr, input logic [17:0] a, input logic [7:0] d);
    @(posedge clk_in); #1;
    hi       = $urandom();
    rdy_in   = rdy;
    cpu_wr   = wr;
    cpu_a    = {hi[31:18], a};
    cpu_dout = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 18'h0, 8'h00);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    check({tag, "_full"}, {31'h0, io_buffer_full}, 32'h0);
    check({tag, "_done"}, {31'h0, program_done}, 32'h0);
    check({tag, "_cpu_din"}, {24'h0, cpu_din}, {24'h0, ram_rdata});
  endtask

  logic [17:0] ra;
  int          kind;

  initial begin
    repeat (3) @(posedge clk_in);
    #2 check_reset_state("reset");
    @(posedge clk_in); #1 rst_in = 1'b1;

    // Single TX byte with the UART ready.
    tx_ready = 1'b1;
    bus(1'b1, 1'b1, 18'h30000, 8'h41);
    bus(1'b0, 1'b0, 18'h0, 8'h00);
    @(negedge clk_in);
    check("t1_tx_data", {24'h0, tx_data}, 32'h41);
    check("t1_tx_valid", {31'h0, tx_valid}, 32'h1);
    idle(1);
    @(negedge clk_in);
    check("t1_popped", {31'h0, tx_valid}, 32'h0);

    // Fill past full with the UART stalled, then drain.
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus(1'b1, 1'b1, 18'h30000, 8'h10 + 8'(i));
      if (i == 12) begin
        @(negedge clk_in);
        check("t2_not_full_13", {31'h0, io_buffer_full}, 32'h0);
      end
    end
    idle(1);
    @(negedge clk_in);
    check("t2_full", {31'h0, io_buffer_full}, 32'h1);
    tx_ready = 1'b1;
    idle(20);
    @(negedge clk_in);
    check("t2_drained", {31'h0, tx_valid}, 32'h0);
    check("t2_sb_empty", tx_sb.size(), 32'h0);

    // Zero byte ignored, stop write pushes 0x00 and sets program_done.
    bus(1'b1, 1'b1, 18'h30000, 8'h00);
    bus(1'b1, 1'b1, 18'h30004, 8'h99);
    idle(3);

    // Snapshot bytes across four reads with stalls between them.
    bus(1'b1, 1'b0, 18'h30004, 8'h00);
    bus(1'b1, 1'b0, 18'h30005, 8'h00);
    idle(2);
    bus(1'b1, 1'b0, 18'h30006, 8'h00);
    idle(1);
    bus(1'b1, 1'b0, 18'h30007, 8'h00);
    idle(2);

    // RX path: two bytes offered, three reads.
    rx_valid = 1'b1; rx_data = 8'h55;
    idle(1);
    rx_data = 8'hAA;
    bus(1'b1, 1'b0, 18'h30000, 8'h00);
    rx_valid = 1'b0;
    bus(1'b1, 1'b0, 18'h30000, 8'h00);
    bus(1'b1, 1'b0, 18'h30000, 8'h00);
    idle(2);

    // RAM write, stalled write attempt, then read back.
    bus(1'b1, 1'b1, 18'h01234, 8'hC3);
    bus(1'b0, 1'b1, 18'h01234, 8'h5A);
    bus(1'b1, 1'b0, 18'h01234, 8'h00);
    bus(1'b0, 1'b0, 18'h0, 8'h00);
    @(negedge clk_in);
    check("t6_ram_read", {24'h0, cpu_din}, 32'hC3);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        0:       ra = 18'h30000;
        1:       ra = 18'h30004;
        2:       ra = 18'h30005 + 18'($urandom_range(0, 2));
        3:       ra = {2'b11, 16'($urandom())};
        default: ra = {1'($urandom()), 1'b0, 16'h1230 + 16'($urandom_range(0, 7))};
      endcase
      bus(($urandom_range(0, 4) != 0), 1'($urandom()), ra,
          ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom()));
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom());
    end

    // Asynchronous reset in the middle of a FIFO fill.
    tx_ready = 1'b0; rx_valid = 1'b0;
    idle(25);
    for (int i = 0; i < 5; i++) bus(1'b1, 1'b1, 18'h30000, 8'hE0 + 8'(i));
    @(posedge clk_in); #2;
    rdy_in = 1'b0; cpu_wr = 1'b0; rst_in = 1'b0;
    #1 check_reset_state("mid_reset");
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    idle(1);
    @(negedge clk_in);
    check("post_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("post_reset_done", {31'h0, program_done}, 32'h0);
    bus(1'b1, 1'b0, 18'h30000, 8'h00);
    bus(1'b1, 1'b1, 18'h30000, 8'h77);
    tx_ready = 1'b1;
    idle(4);
    @(negedge clk_in);
    check("final_drained", {31'h0, tx_valid}, 32'h0);
    check("final_sb_empty", tx_sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
